serial_minuend_adder: RTL and testbench
=======================================

Name: serial_minuend_adder

Overview:
- Bit-serial inverse of the full-subtract datapath: given difference d, subtrahend b and borrowIn, it reconstructs the minuend a = d + b + borrowIn.
- Processes one bit per clock, LSB first, reusing a single 1-bit full-adder cell with a registered carry.
- Used as a self-check companion to the subtractor: carryOut equals the subtractor's final borrowOut for the same operands.
- Start/busy/done handshake.

Parameters:
- SIZE, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- diffIn  input  SIZE  difference operand d
- bIn  input  SIZE  subtrahend operand b
- borrowIn  input  1  borrow-in of the original subtract; seeds the carry
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid from this cycle
- minuend  output  SIZE  reconstructed a, held until the next accepted start
- carryOut  output  1  final carry, i.e. the original borrowOut

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: state=IDLE, busy=0, done=0, minuend=0, carryOut=0.
  - Also cleared: bit counter, operand shift registers, carry register.
- States: IDLE, RUN, DONE, encoded in 2 bits; the unused code returns to IDLE.
- Capture edge E0: start=1 in IDLE or DONE.
  - dReg<=diffIn, bReg<=bIn, carry<=borrowIn, count<=0.
  - minuend<=0 and carryOut<=0.
  - state<=RUN.
- RUN, each edge, one bit per edge:
  - s = dReg[0]^bReg[0]^carry.
  - carry <= majority(dReg[0], bReg[0], carry).
  - dReg and bReg shift right by 1.
  - minuend shifts right with s entering at bit SIZE-1.
  - count increments.
- End of RUN: on the edge where count==SIZE-1 (edge E_SIZE):
  - state<=DONE.
  - carryOut<=the new carry.
  - After SIZE RUN edges, minuend holds the full result.
- busy = (state==RUN); high from after E0 through after E_SIZE-1. Registered or decoded from registered state only; no combinational path from inputs.
- done = (state==DONE); lasts exactly one cycle, after edge E_SIZE.
- Latency: start edge to done-high is SIZE edges.
  - SIZE=8: start sampled at edge 0, done high between edges 8 and 9.
- DONE, next edge:
  - If start=1, capture new operands (back-to-back, no idle cycle).
  - Otherwise go to IDLE. minuend and carryOut are held.
- start while in RUN is ignored. Operands are not re-sampled, and diffIn/bIn/borrowIn may change freely during RUN.
- Arithmetic is modulo 2^SIZE; any overflow appears only on carryOut.
- Reset mid-RUN aborts immediately:
  - All outputs go to 0.
  - No done pulse is produced for the aborted operation.
- count width: $clog2(SIZE), minimum 1; it never wraps past SIZE-1 in RUN.

Decomposition:
- Shared package serial_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default SIZE=8.
  - The package is shared with the subtractor-side serial blocks.
- One sub-module: full_add (1-bit combinational, outputs sum and carryOut; inputs a, b, carryIn).
  - Port order mirrors full_subtract: outputs first.
  - Instantiated once.

Test Plan:
- Zero: diffIn=8'h00, bIn=8'h00, borrowIn=0, start at edge 0 -> busy high edges 1-8; done pulse after edge 8; minuend=8'h00; carryOut=0.
- Borrow seed: diffIn=8'h5A, bIn=8'h25, borrowIn=1 -> minuend=8'h80, carryOut=0.
- Overflow: diffIn=8'hFF, bIn=8'h01, borrowIn=0 -> minuend=8'h00, carryOut=1. Also check against full_subtract: 8'h00-8'h01 gives d=8'hFF with borrowOut=1.
- Start ignored in RUN: launch 8'h12+8'h34 (borrowIn=0), pulse start with different operands at edge 3 -> result 8'h46, a single done pulse, no re-capture.
- Reset mid-op: drop rst_n between edges 3 and 4 (asynchronously) -> busy, done, minuend and carryOut are 0 immediately; state IDLE; no done pulse afterwards; a new start after release works.
- Back-to-back: hold start=1 during the DONE cycle with 8'h01+8'h01 (borrowIn=1) -> captured at that edge; first result is held; second done after 8 more edges with minuend=8'h03.

Source files
------------

// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
// Definitions shared by the bit-serial subtract / minuend-reconstruct blocks:
// FSM state codes, the default operand width and a counter-width helper.
// ----------------------------------------------------------------------------
package serial_pkg;

    // Default operand/result width of the serial datapaths.
    localparam int DEFAULT_SIZE = 8;

    // Two-bit FSM state code; code 2'd3 is unused and recovers to IDLE.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Width of a bit counter that must hold 0..size-1, never less than 1 bit.
    function automatic int cnt_width(input int size);
        if (size <= 2) begin
            return 1;
        end else begin
            return $clog2(size);
        end
    endfunction

endpackage

// File: rtl/full_add.sv
// ----------------------------------------------------------------------------
// full_add
// Single-bit combinational full adder. Port order mirrors full_subtract
// (outputs first) so the two cells can be swapped in the serial datapaths.
//   sum      : a ^ b ^ carryIn
//   carryOut : majority(a, b, carryIn)
//   a, b     : operand bits
//   carryIn  : incoming carry
// ----------------------------------------------------------------------------
module full_add (
    output logic sum,
    output logic carryOut,
    input  logic a,
    input  logic b,
    input  logic carryIn
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        sum      = a ^ b ^ carryIn;
        carryOut = (a & b) | (a & carryIn) | (b & carryIn);
    end

endmodule

// File: rtl/serial_minuend_adder.sv
// ----------------------------------------------------------------------------
// serial_minuend_adder
// Bit-serial reconstruction of the minuend of a subtraction:
//     a = d + b + borrowIn   (modulo 2^SIZE, overflow on carryOut)
// One bit per clock, LSB first, through a single full_add cell with a
// registered carry. carryOut equals the subtractor's final borrowOut.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : request, accepted only in IDLE or DONE
//   diffIn    : difference operand d        (SIZE bits)
//   bIn       : subtrahend operand b        (SIZE bits)
//   borrowIn  : borrow-in of the original subtract, seeds the carry
//   busy      : high while bits are being processed
//   done      : one-cycle pulse, result valid from this cycle
//   minuend   : reconstructed a, held until the next accepted start
//   carryOut  : final carry (original borrowOut)
// ----------------------------------------------------------------------------
module serial_minuend_adder
    import serial_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] diffIn,
    input  logic [SIZE-1:0] bIn,
    input  logic            borrowIn,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] minuend,
    output logic            carryOut
);

    localparam int CNT_W = cnt_width(SIZE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [SIZE-1:0]   d_q,         d_d;
    logic [SIZE-1:0]   b_q,         b_d;
    logic              carry_q,     carry_d;
    logic [SIZE-1:0]   minuend_q,   minuend_d;
    logic              carry_out_q, carry_out_d;

    logic              fa_sum_s;
    logic              fa_carry_s;

    // The one adder cell, always fed by the low bits of the shift registers.
    full_add u_full_add (
        .sum      (fa_sum_s),
        .carryOut (fa_carry_s),
        .a        (d_q[0]),
        .b        (b_q[0]),
        .carryIn  (carry_q)
    );

    // Next-state logic: operand capture, serial shifting and FSM sequencing.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        d_d         = d_q;
        b_d         = b_q;
        carry_d     = carry_q;
        minuend_d   = minuend_q;
        carry_out_d = carry_out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Capture clears the previous result so a half-built
                    // value is never mistaken for the old one.
                    d_d         = diffIn;
                    b_d         = bIn;
                    carry_d     = borrowIn;
                    count_d     = '0;
                    minuend_d   = '0;
                    carry_out_d = 1'b0;
                    state_d     = ST_RUN;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_RUN: begin
                d_d       = {1'b0, d_q[SIZE-1:1]};
                b_d       = {1'b0, b_q[SIZE-1:1]};
                carry_d   = fa_carry_s;
                minuend_d = {fa_sum_s, minuend_q[SIZE-1:1]};
                if (count_q == LAST_BIT) begin
                    // Counter stays at SIZE-1 rather than wrapping.
                    carry_out_d = fa_carry_s;
                    state_d     = ST_DONE;
                end else begin
                    count_d     = count_q + CNT_W'(1);
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            d_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            minuend_q   <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            d_q         <= d_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            minuend_q   <= minuend_d;
            carry_out_q <= carry_out_d;
        end
    end

    // Status flags are decoded from the registered state only.
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign minuend  = minuend_q;
    assign carryOut = carry_out_q;

endmodule

// File: tb/tb_serial_minuend_adder.sv
module tb_serial_minuend_adder;

    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [SIZE-1:0] diffIn = 8'h00;
    logic [SIZE-1:0] bIn = 8'h00;
    logic            borrowIn = 1'b0;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] minuend;
    logic            carryOut;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_minuend_adder #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .diffIn   (diffIn),
        .bIn      (bIn),
        .borrowIn (borrowIn),
        .busy     (busy),
        .done     (done),
        .minuend  (minuend),
        .carryOut (carryOut)
    );

    // Drive operands and a one-cycle start; returns 1 time unit after edge E0.
    task automatic launch(input logic [7:0] d, input logic [7:0] b, input logic bi);
        @(negedge clk);
        diffIn   = d;
        bIn      = b;
        borrowIn = bi;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if (minuend !== 8'h00) $display("FAIL reset_minuend: got %h expected 00", minuend); else passed++;
        checks++; if (carryOut !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carryOut); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL idle_no_start_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_zero();
        launch(8'h00, 8'h00, 1'b0);
        checks++; if (busy !== 1'b1) $display("FAIL zero_busy_e0: got %b expected 1", busy); else passed++;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            checks++; if (busy !== (i < 8)) $display("FAIL zero_busy_e%0d: got %b expected %b", i, busy, (i < 8)); else passed++;
            checks++; if (done !== (i == 8)) $display("FAIL zero_done_e%0d: got %b expected %b", i, done, (i == 8)); else passed++;
        end
        checks++; if (minuend !== 8'h00) $display("FAIL zero_minuend: got %h expected 00", minuend); else passed++;
        checks++; if (carryOut !== 1'b0) $display("FAIL zero_carry: got %b expected 0", carryOut); else passed++;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) $display("FAIL zero_done_pulse_width: got %b expected 0", done); else passed++;
    endtask

    task automatic test_borrow_seed();
        int n;
        launch(8'h5A, 8'h25, 1'b1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 8) $display("FAIL seed_latency: got %0d expected 8", n); else passed++;
        checks++; if (minuend !== 8'h80) $display("FAIL seed_minuend: got %h expected 80", minuend); else passed++;
        checks++; if (carryOut !== 1'b0) $display("FAIL seed_carry: got %b expected 0", carryOut); else passed++;
    endtask

    task automatic test_overflow();
        int n;
        logic [8:0] sub_s;
        // Reference subtract 00 - 01 gives d = FF with borrowOut = 1.
        sub_s = {1'b0, 8'h00} - {1'b0, 8'h01};
        launch(sub_s[7:0], 8'h01, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 8) $display("FAIL ovf_latency: got %0d expected 8", n); else passed++;
        checks++; if (minuend !== 8'h00) $display("FAIL ovf_minuend: got %h expected 00", minuend); else passed++;
        checks++; if (carryOut !== 1'b1) $display("FAIL ovf_carry: got %b expected 1", carryOut); else passed++;
        checks++; if (carryOut !== sub_s[8]) $display("FAIL ovf_vs_borrow: got %b expected %b", carryOut, sub_s[8]); else passed++;
    endtask

    task automatic test_start_ignored();
        int ndone;
        int first_edge;
        launch(8'h12, 8'h34, 1'b0);
        // Operands may change freely once captured.
        diffIn   = 8'hFF;
        bIn      = 8'hFF;
        borrowIn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first_edge = -1;
        for (int i = 4; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_edge < 0) first_edge = i;
            end
        end
        checks++; if (ndone !== 1) $display("FAIL ign_done_count: got %0d expected 1", ndone); else passed++;
        checks++; if (first_edge !== 8) $display("FAIL ign_done_edge: got %0d expected 8", first_edge); else passed++;
        checks++; if (minuend !== 8'h46) $display("FAIL ign_minuend: got %h expected 46", minuend); else passed++;
        checks++; if (carryOut !== 1'b0) $display("FAIL ign_carry: got %b expected 0", carryOut); else passed++;
    endtask

    task automatic test_reset_mid();
        int ndone;
        int n;
        launch(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (minuend !== 8'hC0) $display("FAIL mid_partial: got %h expected c0", minuend); else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL mid_done: got %b expected 0", done); else passed++;
        checks++; if (minuend !== 8'h00) $display("FAIL mid_minuend: got %h expected 00", minuend); else passed++;
        checks++; if (carryOut !== 1'b0) $display("FAIL mid_carry: got %b expected 0", carryOut); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        checks++; if (ndone !== 0) $display("FAIL mid_no_activity: got %0d expected 0", ndone); else passed++;
        launch(8'h5A, 8'h25, 1'b1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 8) $display("FAIL mid_restart_latency: got %0d expected 8", n); else passed++;
        checks++; if (minuend !== 8'h80) $display("FAIL mid_restart_minuend: got %h expected 80", minuend); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        launch(8'hFF, 8'h01, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 8) $display("FAIL b2b_first_latency: got %0d expected 8", n); else passed++;
        diffIn   = 8'h01;
        bIn      = 8'h01;
        borrowIn = 1'b1;
        start    = 1'b1;
        checks++; if (minuend !== 8'h00) $display("FAIL b2b_first_minuend: got %h expected 00", minuend); else passed++;
        checks++; if (carryOut !== 1'b1) $display("FAIL b2b_first_carry: got %b expected 1", carryOut); else passed++;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_captured: got %b expected 1", busy); else passed++;
        checks++; if (carryOut !== 1'b0) $display("FAIL b2b_carry_cleared: got %b expected 0", carryOut); else passed++;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 8) $display("FAIL b2b_second_latency: got %0d expected 8", n); else passed++;
        checks++; if (minuend !== 8'h03) $display("FAIL b2b_second_minuend: got %h expected 03", minuend); else passed++;
        checks++; if (carryOut !== 1'b0) $display("FAIL b2b_second_carry: got %b expected 0", carryOut); else passed++;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) $display("FAIL b2b_single_pulse: got %b expected 0", done); else passed++;
        checks++; if (minuend !== 8'h03) $display("FAIL b2b_held: got %h expected 03", minuend); else passed++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_borrow_seed();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
